// File: rtl/req_arbiter_8.sv
// Eight-requester arbiter: fixed-priority or round-robin selection, grant held until release,
// with a hold-timeout watchdog. Outputs are registered; gnt_id drives the shared datapath mux.
module req_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_rr,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    last_id;
    logic [3:0]    win;
    logic          rel;
    logic          expire;

    // Highest-index-wins search starting just below base and wrapping; base itself ranks last.
    // Bit 3 of the result flags that any request was found.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 8; k >= 1; k--) begin
            idx = base - 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        win    = pick(req, mode_rr ? last_id : 3'd0);
        rel    = done[gnt_id] | ~req[gnt_id];
        expire = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
            last_id  <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win[3]) begin
                        state    <= GRANT;
                        gnt      <= 8'b1 << win[2:0];
                        gnt_id   <= win[2:0];
                        last_id  <= win[2:0];
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    // A normal release takes precedence over the watchdog in the same cycle.
                    if (rel) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end else if (expire) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        timeout <= 1'b1;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_req_arbiter_8.sv
// Scoreboard bench for req_arbiter_8: a cycle-level behavioural model queues the expected
// outputs for every clock; a negedge monitor pops and compares them against the DUT.
module tb_req_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_rr;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    req_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_rr  (mode_rr),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       t;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model state: owner index (-1 = none), cycles held so far, rr pointer, last id, pulse.
    int owner = -1;
    int held  = 0;
    int last  = 0;
    int mid   = 0;
    bit tout  = 1'b0;

    function automatic int winner(input logic [7:0] r, input int base);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (base - k + 8) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven, queue the result.
    task automatic step();
        exp_t e;
        tout = 1'b0;
        if (rst) begin
            owner = -1; mid = 0; last = 0; held = 0;
        end else if (owner < 0) begin
            int w;
            w = winner(req, mode_rr ? last : 0);
            if (w >= 0) begin
                owner = w; mid = w; last = w; held = 1;
            end
        end else if (done[owner] || !req[owner]) begin
            owner = -1;
        end else if (MAX_HOLD != 0 && held == MAX_HOLD) begin
            owner = -1; tout = 1'b1;
        end else begin
            held++;
        end
        e.g  = (owner >= 0) ? 8'(1 << owner) : 8'h00;
        e.id = 3'(mid);
        e.v  = (owner >= 0);
        e.t  = tout;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            check("gnt", int'(gnt), int'(me.g));
            check("gnt_id", int'(gnt_id), int'(me.id));
            check("gnt_valid", int'(gnt_valid), int'(me.v));
            check("timeout", int'(timeout), int'(me.t));
            check("onehot0", int'($onehot0(gnt)), 1);
        end
    end

    initial begin
        rst = 1'b1; mode_rr = 1'b0; req = 8'hFF; done = 8'h00;
        repeat (3) step();

        // Fixed priority, release by done, then the lower requester.
        rst = 1'b0; req = 8'b0010_0100;
        step(); step();
        done = 8'h20; req = 8'h04; step();
        done = 8'h00; step(); step();
        req = 8'h00; step(); step();

        // Round robin with every requester active, each owner releasing after 2 cycles.
        mode_rr = 1'b1; req = 8'hFF;
        for (int n = 0; n < 30; n++) begin
            done = (owner >= 0 && held == 2) ? 8'(1 << owner) : 8'h00;
            step();
        end
        done = 8'h00; req = 8'h00; step(); step();

        // Watchdog with a single persistent requester.
        mode_rr = 1'b0; req = 8'h01;
        repeat (40) step();

        // done coinciding with the last permitted hold cycle.
        for (int n = 0; n < 40; n++) begin
            done = (owner == 0 && held == MAX_HOLD) ? 8'h01 : 8'h00;
            step();
        end
        done = 8'h00; req = 8'h00; step(); step();

        // done from a non-owner is ignored.
        req = 8'h04; repeat (3) step();
        done = 8'h80; step();
        done = 8'h00; repeat (2) step();
        req = 8'h00; step(); step();

        // Reset mid-grant, then round robin restarts from pointer 0.
        req = 8'h10;
        for (int n = 0; n < 4 && owner != 4; n++) step();
        step();
        rst = 1'b1; step();
        rst = 1'b0; mode_rr = 1'b1; req = 8'h11; step(); step();
        req = 8'h00; step(); step();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) mode_rr = 1'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            else if ($urandom_range(0, 5) == 0) req = req | 8'($urandom);
            done = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if (owner >= 0 && $urandom_range(0, 7) == 0) done[owner] = 1'b1;
            step();
        end
        rst = 1'b0; req = 8'h00; done = 8'h00;
        step(); step();

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
